dm_byte_sequencer: RTL

Responder side of the data-memory command interface driven by the control unit's DMWr/DMCtrl outputs. It accepts one load or store command (lb/lh/lw/lbu/lhu/sb/sh/sw) and executes it as a little-endian sequence of single-byte accesses on a byte-wide synchronous memory port. Loads are returned sign- or zero-extended. A busy/done handshake lets the core stall for the 1-4 byte transfer.

---
 rtl/dm_pkg.sv | 42 ++++
 rtl/dm_byte_sequencer_if.sv | 30 +++
 rtl/dm_load_extend.sv | 22 ++
 rtl/dm_byte_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared command codes, FSM states and command decode helpers for the byte-serial data-memory sequencer.
// Pure declarations: no latency, no flow control.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } dm_state_e;

  function automatic logic [2:0] dm_nbytes(input logic [2:0] ctrl);
    logic [2:0] n;
    n = 3'd1;
    case (ctrl)
      DM_B, DM_BU: n = 3'd1;
      DM_H, DM_HU: n = 3'd2;
      DM_W:        n = 3'd4;
      default:     n = 3'd1;
    endcase
    return n;
  endfunction

  // Unsigned widths only make sense for loads; stores of bu/hu are rejected.
  function automatic logic dm_legal(input logic wr, input logic [2:0] ctrl);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      DM_B, DM_H, DM_W: ok = 1'b1;
      DM_BU, DM_HU:     ok = ~wr;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_byte_sequencer_if.sv
// Command-side and byte-memory-side signals of the sequencer bundled into one interface.
// slave = the sequencer; master = the core plus the memory it drives.
interface dm_byte_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              DMStart;
  logic              DMWr;
  logic [2:0]        DMCtrl;
  logic [ADDR_W-1:0] DMAddress;
  logic [31:0]       DMDataWr;
  logic [31:0]       DMDataRd;
  logic              DMBusy;
  logic              DMDone;
  logic              DMErr;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRdEn;
  logic              MemWrEn;
  logic [7:0]        MemWrData;
  logic [7:0]        MemRdData;

  modport slave (
    input  DMStart, DMWr, DMCtrl, DMAddress, DMDataWr, MemRdData,
    output DMDataRd, DMBusy, DMDone, DMErr, MemAddr, MemRdEn, MemWrEn, MemWrData
  );

  modport master (
    output DMStart, DMWr, DMCtrl, DMAddress, DMDataWr, MemRdData,
    input  DMDataRd, DMBusy, DMDone, DMErr, MemAddr, MemRdEn, MemWrEn, MemWrData
  );
endinterface

// File: rtl/dm_load_extend.sv
// Sign/zero extension of an assembled little-endian load word according to the access width.
// Purely combinational, no flow control.
module dm_load_extend
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ctrl,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (ctrl)
      DM_B:    result = {{24{word[7]}}, word[7:0]};
      DM_H:    result = {{16{word[15]}}, word[15:0]};
      DM_BU:   result = {24'd0, word[7:0]};
      DM_HU:   result = {16'd0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_byte_sequencer.sv
// Runs one lb/lh/lw/lbu/lhu/sb/sh/sw as 1-4 single-byte accesses on a byte-wide synchronous memory.
// Done after N+1 cycles (store), N+2 (load) or 1 (illegal); DMBusy stalls the core, DMStart is dropped while busy.
module dm_byte_sequencer
  import dm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  dm_byte_sequencer_if.slave bus
);

  dm_state_e         state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              accept;
  logic              last_byte;
  logic [1:0]        last_idx;

  logic              wr_q;
  logic [2:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic [31:0]       asm_q;
  logic [31:0]       asm_merged;
  logic              rd_pend_q;
  logic [1:0]        rd_lane_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ext_word;

  logic              rd_en;
  logic              wr_en;

  assign last_idx  = 2'(dm_nbytes(ctrl_q) - 3'd1);
  assign last_byte = (k_q == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.DMStart) begin
          accept  = 1'b1;
          k_d     = 2'd0;
          state_d = dm_legal(bus.DMWr, bus.DMCtrl) ? XFER : DONE;
        end
      end
      XFER: begin
        rd_en = ~wr_q;
        wr_en = wr_q;
        if (last_byte) begin
          state_d = wr_q ? DONE : TAIL;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      TAIL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields are frozen at acceptance so the core may change its outputs while we run.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      ctrl_q  <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= bus.DMWr;
      ctrl_q  <= bus.DMCtrl;
      addr_q  <= bus.DMAddress;
      wdata_q <= bus.DMDataWr;
      err_q   <= ~dm_legal(bus.DMWr, bus.DMCtrl);
    end
  end

  // Read data lags its strobe by a cycle; remember which lane it belongs to.
  always_comb begin
    asm_merged = asm_q;
    if (rd_pend_q) begin
      asm_merged[{rd_lane_q, 3'b000} +: 8] = bus.MemRdData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q     <= 32'd0;
      rd_pend_q <= 1'b0;
      rd_lane_q <= 2'd0;
      rdata_q   <= 32'd0;
    end else begin
      rd_pend_q <= rd_en;
      rd_lane_q <= k_q;
      if (accept) begin
        asm_q <= 32'd0;
      end else begin
        asm_q <= asm_merged;
      end
      if (state_q == TAIL) begin
        rdata_q <= ext_word;
      end
    end
  end

  dm_load_extend u_extend (
    .word   (asm_merged),
    .ctrl   (ctrl_q),
    .result (ext_word)
  );

  assign bus.MemAddr   = addr_q + ADDR_W'(k_q);
  assign bus.MemWrData = wdata_q[{k_q, 3'b000} +: 8];
  assign bus.MemRdEn   = rd_en;
  assign bus.MemWrEn   = wr_en;
  assign bus.DMBusy    = (state_q == XFER) || (state_q == TAIL);
  assign bus.DMDone    = (state_q == DONE);
  assign bus.DMErr     = (state_q == DONE) && err_q;
  assign bus.DMDataRd  = rdata_q;

endmodule
